ram_responder: RTL and testbench
================================

# ram_responder

Synthesisable RAM-side responder for the memory controller's RAM port. It accepts word reads and writes on `ramREN`/`ramWEN`/`ramaddr`/`ramstore` and holds a word array internally. It answers with `ramstate` (`FREE`/`BUSY`/`ACCESS`/`ERROR` from `cpu_types_pkg::ramstate_t`) after a programmable latency, and returns `ramload`. It replaces the behavioural RAM model beneath `memory_control`, so arbitration and wait logic can be exercised against a cycle-exact latency.

## Interface
- `LAT`, 2, wait cycles spent in `BUSY` per transaction; legal range 1..15.
- `AW`, 10, word-address bits; depth = 2^AW words of 32 bits.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `ramREN`  in  1  read request; level, held until `ACCESS`.
- `ramWEN`  in  1  write request; level, held until `ACCESS`.
- `ramaddr`  in  32  byte address; word index is `ramaddr[AW+1:2]`.
- `ramstore`  in  32  write data.
- `ramload`  out  32  read data; registered.
- `ramstate`  out  2  `ramstate_t`; registered.

## Operation
- Output FSM states: `FREE`, `BUSY`, `ACCESS`, `ERROR`. `ramstate` equals the FSM state.
- Internal registers:
  - 4-bit down-counter `cnt`.
  - Captured request `c_addr`, `c_ren`, `c_wen`, `c_store`.
- Legal request: exactly one of `ramREN`/`ramWEN` is high, `ramaddr[1:0]==0`, and `ramaddr[31:AW+2]==0`.
- Illegal request: both enables high, a misaligned address, or an address out of range.
- `FREE` or `ACCESS`:
  - No request -> `FREE`.
  - Legal request -> `BUSY`; capture the request; `cnt<=LAT`.
  - Illegal request -> `ERROR`.
- `BUSY`:
  - Request dropped (both enables low) -> `FREE` (abort); the memory is untouched.
  - Live request differs from the captured one (addr, enables, or `ramstore` when writing) -> stay `BUSY`; recapture; `cnt<=LAT`.
  - Matching request and `cnt==1` -> `ACCESS`.
    - Read: `ramload<=mem[c_addr]`.
    - Write: `mem[c_addr]<=c_store`, committed on this edge.
  - Matching request and `cnt>1` -> `cnt<=cnt-1`.
  - An illegal live request is treated as differing and goes to `ERROR`.
- `ERROR`: lasts one cycle with `ramload<=32'hBAD1BAD1`, then the state is re-evaluated as from `FREE`. A persistent illegal request therefore holds `ERROR`.
- A request still asserted in `ACCESS` starts a new transaction. A repeated read or write is harmless; the controller must deassert in the `ACCESS` cycle to avoid a repeat.
- `ramload` changes only on read completion, on entering `ERROR`, or on reset.

## Timing
- Reset values:
  - `ramstate=FREE`, `ramload=0`, `cnt=0`, captured registers 0.
  - Memory contents are not reset.
- Latency: request first high in cycle 0 (state `FREE`) -> `BUSY` in cycles 1..LAT -> `ACCESS` in cycle LAT+1, with read data valid in that same cycle.
- Back-to-back transactions: a new request presented in the `ACCESS` cycle is `BUSY` the next cycle, giving a throughput of one transaction per LAT+1 cycles.
- Write-then-read to the same word: the read returns the new data, because the write commits before `ACCESS` is visible.
- Reset during `BUSY`: asynchronous return to `FREE`; the pending write is discarded; the memory is unchanged.
- Counter wrap: `cnt` is never decremented below 1; a reload always takes priority.

## Configuration
- `RAM_RESPONDER_ERROR_EN` defined: full legality checking and the `ERROR` state, as described above.
- Not defined:
  - `ERROR` is never produced.
  - Address bits above `AW+1` and bits [1:0] are ignored, so the address wraps modulo the depth.
  - Both enables high is treated as a write.

## Test plan
- Reset, `LAT=2`: read of word 0x10 -> `ramstate` FREE, BUSY, BUSY, ACCESS; `ramload` is the preloaded `mem[4]` in the `ACCESS` cycle.
- Write 0xDEADBEEF to 0x40, then read 0x40 -> `ACCESS` after 3 cycles each; the read returns 0xDEADBEEF.
- Change `ramaddr` 0x40->0x44 in the first `BUSY` cycle -> `BUSY` is extended to 2 cycles from the change; data comes from 0x44.
- Drop `ramWEN` in `BUSY` -> `FREE` the next cycle; a later read of the address returns the old value.
- With the macro defined, `ramaddr=0x2` -> `ERROR` with `ramload=0xBAD1BAD1`; with it undefined, the same request is serviced as 0x0.
- Assert `RST` mid-`BUSY` write -> `ramstate=FREE` and `ramload=0` immediately; the memory word is unchanged.

Source files
------------

// File: rtl/ram_responder_if.sv
// RAM-port state type and the request/response bundle between memory_control and ram_responder.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_responder_if;
  import cpu_types_pkg::*;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// Word RAM answering FREE/BUSY/ACCESS(/ERROR) after LAT busy cycles; ramload/ramstate registered.
// Define RAM_RESPONDER_ERROR_EN for legality checking and the ERROR state; otherwise addresses wrap.
module ram_responder #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input logic            CLK,
  input logic            RST,
  ram_responder_if.slave ram
);
  import cpu_types_pkg::*;

  localparam logic [3:0]  LAT_CNT  = 4'(LAT);
  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  ramstate_t     state;
  logic [3:0]    cnt;
  logic [AW-1:0] c_addr;
  logic          c_ren;
  logic          c_wen;
  logic [31:0]   c_store;
  logic [31:0]   load_q;

  logic [31:0]   mem [0:(1<<AW)-1];

  logic          req;
  logic          legal;
  logic          l_ren;
  logic          l_wen;
  logic [AW-1:0] l_addr;
  logic          same;
  logic          commit;

  assign req    = ram.ramREN | ram.ramWEN;
  assign l_addr = ram.ramaddr[AW+1:2];

`ifdef RAM_RESPONDER_ERROR_EN
  assign legal = (ram.ramREN ^ ram.ramWEN) &&
                 (ram.ramaddr[1:0] == 2'b00) &&
                 (ram.ramaddr[31:AW+2] == '0);
  assign l_ren = ram.ramREN;
  assign l_wen = ram.ramWEN;
`else
  // Without checking, both enables collapse to a write and stray address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram.ramaddr[31:AW+2], ram.ramaddr[1:0]};
  assign legal = req;
  assign l_ren = ram.ramREN & ~ram.ramWEN;
  assign l_wen = ram.ramWEN;
`endif

  assign same = (l_addr == c_addr) && (l_ren == c_ren) && (l_wen == c_wen) &&
                (!l_wen || (ram.ramstore == c_store));

  // The completing edge of a matching BUSY transaction.
  assign commit = (state == BUSY) && req && legal && same && (cnt == 4'd1);

  always_ff @(posedge CLK) begin
    if (commit && c_wen) begin
      mem[c_addr] <= c_store;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FREE;
      cnt     <= 4'd0;
      c_addr  <= '0;
      c_ren   <= 1'b0;
      c_wen   <= 1'b0;
      c_store <= 32'd0;
      load_q  <= 32'd0;
    end else begin
      case (state)
        BUSY: begin
          if (!req) begin
            state <= FREE;
          end else if (!legal) begin
            state  <= ERROR;
            load_q <= ERR_WORD;
          end else if (!same) begin
            c_addr  <= l_addr;
            c_ren   <= l_ren;
            c_wen   <= l_wen;
            c_store <= ram.ramstore;
            cnt     <= LAT_CNT;
          end else if (cnt == 4'd1) begin
            state <= ACCESS;
            if (c_ren) begin
              load_q <= mem[c_addr];
            end
          end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end
        end
        // FREE, ACCESS and ERROR all evaluate the live request afresh.
        default: begin
          if (!req) begin
            state <= FREE;
          end else if (!legal) begin
            state  <= ERROR;
            load_q <= ERR_WORD;
          end else begin
            state   <= BUSY;
            c_addr  <= l_addr;
            c_ren   <= l_ren;
            c_wen   <= l_wen;
            c_store <= ram.ramstore;
            cnt     <= LAT_CNT;
          end
        end
      endcase
    end
  end

  assign ram.ramstate = state;
  assign ram.ramload  = load_q;

endmodule

// File: tb/tb_ram_responder.sv
// Transaction-level bench for ram_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int LAT   = 2;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic RST;

  ram_responder_if ram ();

  ram_responder #(.LAT(LAT), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .ram (ram)
  );

  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          ref_vld [DEPTH];
  logic [31:0] last_load;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input bit ren, input bit wen, input logic [31:0] addr, input logic [31:0] data);
    ram.ramREN   = ren;
    ram.ramWEN   = wen;
    ram.ramaddr  = addr;
    ram.ramstore = data;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (n) begin
      @(negedge CLK);
      chk("idle_state", ram.ramstate, FREE);
    end
  endtask

  // Request already presented; expect LAT busy cycles then the access cycle.
  task automatic finish_txn(input bit wen, input logic [31:0] addr, input logic [31:0] data, input string tag);
    int w;
    w = int'(addr[AW+1:2]);
    for (int i = 0; i < LAT; i++) begin
      @(negedge CLK);
      chk({tag, "_busy"}, ram.ramstate, BUSY);
      chk({tag, "_hold"}, ram.ramload, last_load);
    end
    @(negedge CLK);
    chk({tag, "_access"}, ram.ramstate, ACCESS);
    if (wen) begin
      ref_mem[w] = data;
      ref_vld[w] = 1'b1;
    end else begin
      chk({tag, "_rdata"}, ram.ramload, ref_mem[w]);
      last_load = ref_mem[w];
    end
  endtask

  task automatic txn(input bit ren, input bit wen, input logic [31:0] addr, input logic [31:0] data, input string tag);
    drive(ren, wen, addr, data);
    finish_txn(wen, addr, data, tag);
  endtask

  initial begin
    RST       = 1'b1;
    last_load = 32'd0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge CLK);
    chk("rst_state", ram.ramstate, FREE);
    chk("rst_load", ram.ramload, 32'd0);
    RST = 1'b0;
    idle(1);

    // Preload word 4, then read it back.
    txn(1'b0, 1'b1, 32'h10, 32'hA5A50004, "pre10");
    idle(1);
    txn(1'b1, 1'b0, 32'h10, 32'd0, "rd10");
    idle(1);

    // Write-then-read.
    txn(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "wr40");
    idle(1);
    txn(1'b1, 1'b0, 32'h40, 32'd0, "rd40");
    idle(1);

    // Address change in the first busy cycle restarts the wait.
    txn(1'b0, 1'b1, 32'h44, 32'h44440044, "pre44");
    idle(1);
    drive(1'b1, 1'b0, 32'h40, 32'd0);
    @(negedge CLK);
    chk("chg_first_busy", ram.ramstate, BUSY);
    drive(1'b1, 1'b0, 32'h44, 32'd0);
    finish_txn(1'b0, 32'h44, 32'd0, "chg");
    idle(1);

    // Dropped write leaves memory untouched.
    txn(1'b0, 1'b1, 32'h48, 32'h00000048, "pre48");
    idle(1);
    drive(1'b0, 1'b1, 32'h48, 32'hFFFF0000);
    @(negedge CLK);
    chk("drop_busy", ram.ramstate, BUSY);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    chk("drop_free", ram.ramstate, FREE);
    chk("drop_load", ram.ramload, last_load);
    idle(1);
    txn(1'b1, 1'b0, 32'h48, 32'd0, "rd48");
    idle(1);

    txn(1'b0, 1'b1, 32'h0, 32'h12340000, "pre0");
    idle(1);
`ifdef RAM_RESPONDER_ERROR_EN
    drive(1'b1, 1'b0, 32'h2, 32'd0);
    @(negedge CLK);
    chk("unal_state", ram.ramstate, ERROR);
    chk("unal_load", ram.ramload, 32'hBAD1BAD1);
    last_load = 32'hBAD1BAD1;
    @(negedge CLK);
    chk("unal_persist", ram.ramstate, ERROR);
    idle(1);
    drive(1'b1, 1'b1, 32'h40, 32'd0);
    @(negedge CLK);
    chk("both_state", ram.ramstate, ERROR);
    idle(1);
    drive(1'b1, 1'b0, 32'h1000, 32'd0);
    @(negedge CLK);
    chk("range_state", ram.ramstate, ERROR);
    idle(1);
    txn(1'b1, 1'b0, 32'h40, 32'd0, "rd40b");
    idle(1);
`else
    txn(1'b1, 1'b0, 32'h2, 32'd0, "unal");
    idle(1);
    txn(1'b0, 1'b1, 32'h1040, 32'h00000077, "wrap");
    idle(1);
    txn(1'b1, 1'b0, 32'h40, 32'd0, "rdwrap");
    idle(1);
    txn(1'b1, 1'b1, 32'h44, 32'h55555555, "both");
    idle(1);
    txn(1'b1, 1'b0, 32'h44, 32'd0, "rdboth");
    idle(1);
`endif

    // Reset in the middle of a write.
    txn(1'b0, 1'b1, 32'h50, 32'h50505050, "pre50");
    idle(1);
    txn(1'b1, 1'b0, 32'h10, 32'd0, "rd10b");
    drive(1'b0, 1'b1, 32'h50, 32'hDEAD0050);
    @(negedge CLK);
    chk("rstw_busy", ram.ramstate, BUSY);
    RST = 1'b1;
    #1;
    chk("rstw_state", ram.ramstate, FREE);
    chk("rstw_load", ram.ramload, 32'd0);
    last_load = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    idle(1);
    txn(1'b1, 1'b0, 32'h50, 32'd0, "rd50");
    idle(1);

    // Random traffic, including back-to-back requests presented in the access cycle.
    for (int k = 0; k < 60; k++) begin
      int          w;
      bit          do_wr;
      logic [31:0] a;
      logic [31:0] d;
      w     = int'($urandom_range(0, 63)) * 16 + int'($urandom_range(0, 3));
      do_wr = ($urandom_range(0, 1) == 1) || !ref_vld[w];
      a     = 32'(w) << 2;
      d     = $urandom;
      if (do_wr) txn(1'b0, 1'b1, a, d, "rnd_wr");
      else       txn(1'b1, 1'b0, a, 32'd0, "rnd_rd");
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
